// File: rtl/fft_frame_loader.sv
// fft_frame_loader: packs a valid/ready sample stream into 16-entry
// master_ram frames, waits for the FFT pipeline to settle, then holds
// the frame (frame_ready) until the reader acknowledges it.
module fft_frame_loader #(
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned ADDR_W        = 4,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] data_in,
  output logic              we,
  output logic              frame_ready,
  input  logic              frame_ack,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              err_last
);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] IDX_LAST    = '1;
  localparam logic [7:0]        SETTLE_INIT = 8'(SETTLE_CYCLES);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    fcnt_q, fcnt_d;
  logic                err_q, err_d;
  logic                fill_st;
  logic                accept;
  logic                at_last;

  // Ready is a pure state decode (no path from s_valid); forced low while
  // reset is held so the producer never sees a ready during reset.
  assign fill_st     = (state_q == FILL);
  assign s_ready     = fill_st & rst;
  assign accept      = fill_st & s_valid;
  assign at_last     = (idx_q == IDX_LAST);

  assign write_addr  = addr_q;
  assign data_in     = data_q;
  assign we          = we_q;
  assign frame_ready = (state_q == HOLD);
  assign frame_cnt   = fcnt_q;
  assign err_last    = err_q;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
      idx_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      fcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      fcnt_q  <= fcnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state: fill 16 writes, count down the settle delay, hold for ack.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    fcnt_d  = fcnt_q;
    err_d   = err_q;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          we_d   = 1'b1;
          addr_d = idx_q;
          data_d = s_data;
          // s_last is only checked, never used for framing.
          if (s_last != at_last) begin
            err_d = 1'b1;
          end
          if (at_last) begin
            idx_d   = '0;
            state_d = SETTLE;
            cnt_d   = SETTLE_INIT;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end
      SETTLE: begin
        if (cnt_q == 8'd0) begin
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HOLD: begin
        if (frame_ack) begin
          state_d = FILL;
          fcnt_d  = fcnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Bench for fft_frame_loader: table-driven hold/ack checks plus a write
// scoreboard fed by the stimulus driver and drained by a we monitor.
module tb_fft_frame_loader;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned SETTLE = 4;
  localparam int unsigned CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              s_valid = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_last = 1'b0;
  logic              s_ready;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] data_in;
  logic              we;
  logic              frame_ready;
  logic              frame_ack = 1'b0;
  logic [CNT_W-1:0]  frame_cnt;
  logic              err_last;

  fft_frame_loader #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .SETTLE_CYCLES(SETTLE),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_last(s_last),
    .s_ready(s_ready),
    .write_addr(write_addr),
    .data_in(data_in),
    .we(we),
    .frame_ready(frame_ready),
    .frame_ack(frame_ack),
    .frame_cnt(frame_cnt),
    .err_last(err_last)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int unsigned       cyc;
  } wr_t;

  typedef struct {
    logic       s_valid;
    logic       frame_ack;
    logic       exp_s_ready;
    logic       exp_frame_ready;
    logic [7:0] exp_cnt;
  } vec_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  vec_t        hold_tab[22];
  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  // Bench-side model of the loader.
  logic [ADDR_W-1:0] idx_m = '0;
  logic [CNT_W-1:0]  cnt_m = '0;
  logic              err_m = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive n beats; s_last asserted on beat last_pos. Each accepted beat
  // pushes its expected write, due at the negedge after the accepting edge.
  task automatic send_frame(input int unsigned n, input int unsigned last_pos,
                            input bit bubbles, input bit ack_in_fill,
                            input logic [DATA_W-1:0] base);
    frame_ack = ack_in_fill;
    for (int unsigned i = 0; i < n; i++) begin
      if (bubbles && ($urandom_range(0, 1) == 1)) begin
        s_valid = 1'b0;
        s_data  = DATA_W'($urandom);
        s_last  = 1'b1;
        step();
      end
      s_valid = 1'b1;
      s_data  = base + DATA_W'(i);
      s_last  = (i == last_pos);
      check("s_ready_fill", s_ready, 1);
      exp_q.push_back('{addr: idx_m, data: s_data, cyc: cyc + 1});
      if (s_last != (idx_m == '1)) err_m = 1'b1;
      step();
      idx_m = idx_m + ADDR_W'(1);
    end
    s_valid   = 1'b0;
    s_last    = 1'b0;
    frame_ack = 1'b0;
    check("err_last", err_last, 32'(err_m));
    check("fill_ack_ignored", frame_cnt, 32'(cnt_m));
  endtask

  // Called just after the edge that accepted sample 15: frame_ready must be
  // low for SETTLE+1 edges and high after exactly SETTLE+1 edges.
  task automatic settle_and_hold(input bit ack_early);
    s_valid = 1'b1;
    s_data  = 16'hdead;
    for (int unsigned k = 0; k <= SETTLE; k++) begin
      if (ack_early) frame_ack = 1'b1;
      check("settle_s_ready", s_ready, 0);
      check("settle_frame_ready", frame_ready, 0);
      step();
    end
    s_valid   = 1'b0;
    frame_ack = 1'b0;
    check("frame_ready_rise", frame_ready, 1);
    check("hold_s_ready", s_ready, 0);
    if (ack_early) begin
      step();
      check("early_ack_ready", frame_ready, 1);
      check("early_ack_cnt", frame_cnt, 32'(cnt_m));
    end
  endtask

  task automatic do_ack();
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
    cnt_m     = cnt_m + CNT_W'(1);
    check("ack_frame_ready", frame_ready, 0);
    check("ack_s_ready", s_ready, 1);
    check("ack_frame_cnt", frame_cnt, 32'(cnt_m));
  endtask

  initial begin
    for (int unsigned r = 0; r < 20; r++)
      hold_tab[r] = '{s_valid: 1'b1, frame_ack: 1'b0, exp_s_ready: 1'b0,
                      exp_frame_ready: 1'b1, exp_cnt: 8'd0};
    hold_tab[20] = '{s_valid: 1'b0, frame_ack: 1'b1, exp_s_ready: 1'b1,
                     exp_frame_ready: 1'b0, exp_cnt: 8'd1};
    hold_tab[21] = '{s_valid: 1'b0, frame_ack: 1'b1, exp_s_ready: 1'b1,
                     exp_frame_ready: 1'b0, exp_cnt: 8'd1};

    // Write monitor: every we pulse must match the oldest expected write.
    fork
      forever begin
        @(negedge clk);
        if (rst === 1'b1 && we === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("we_unexpected", 1, 0);
          end else begin
            mon_e = exp_q.pop_front();
            check("wr_addr", write_addr, 32'(mon_e.addr));
            check("wr_data", data_in, 32'(mon_e.data));
            check("wr_cycle", cyc, mon_e.cyc);
          end
        end
      end
    join_none

    // 1: reset values, s_valid high during reset must not be accepted
    s_valid = 1'b1;
    repeat (2) step();
    check("rst_s_ready", s_ready, 0);
    check("rst_we", we, 0);
    check("rst_addr", write_addr, 0);
    check("rst_data", data_in, 0);
    check("rst_frame_ready", frame_ready, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_err_last", err_last, 0);
    s_valid = 1'b0;
    rst = 1'b1;
    step();
    check("rel_s_ready", s_ready, 1);
    check("rel_we", we, 0);

    // 2: one clean frame 0x0001..0x0010, s_last on #16
    send_frame(16, 15, 1'b0, 1'b0, 16'h0001);
    settle_and_hold(1'b0);

    // 3: hold for 20 cycles with s_valid high, then a single ack
    for (int unsigned r = 0; r < 22; r++) begin
      s_valid   = hold_tab[r].s_valid;
      frame_ack = hold_tab[r].frame_ack;
      s_data    = 16'hbeef;
      step();
      check("tab_s_ready", s_ready, 32'(hold_tab[r].exp_s_ready));
      check("tab_frame_ready", frame_ready, 32'(hold_tab[r].exp_frame_ready));
      check("tab_frame_cnt", frame_cnt, 32'(hold_tab[r].exp_cnt));
    end
    s_valid   = 1'b0;
    frame_ack = 1'b0;
    cnt_m     = 8'd1;

    // 4: bubbles with s_last on #8, then a clean frame; err_last sticks
    send_frame(16, 7, 1'b1, 1'b0, DATA_W'($urandom));
    check("err_set", err_last, 1);
    settle_and_hold(1'b0);
    do_ack();
    send_frame(16, 15, 1'b1, 1'b0, DATA_W'($urandom));
    check("err_sticky", err_last, 1);
    settle_and_hold(1'b0);
    do_ack();

    // 5: asynchronous reset after 7 samples, then a full frame from addr 0
    send_frame(7, 99, 1'b0, 1'b0, 16'h7000);
    step();
    check("pre_reset_drain", exp_q.size(), 0);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_s_ready", s_ready, 0);
    check("mid_rst_addr", write_addr, 0);
    check("mid_rst_frame_cnt", frame_cnt, 0);
    check("mid_rst_err", err_last, 0);
    step();
    rst   = 1'b1;
    idx_m = '0;
    cnt_m = '0;
    err_m = 1'b0;
    step();
    check("post_rst_frame_ready", frame_ready, 0);
    send_frame(16, 15, 1'b0, 1'b0, 16'h5a00);
    settle_and_hold(1'b0);
    do_ack();

    // 6: run frame_cnt through its wrap, with early acks on some frames
    for (int unsigned f = 0; f < 255; f++) begin
      send_frame(16, 15, 1'b0, (f % 37) == 3, DATA_W'($urandom));
      settle_and_hold((f % 50) == 7);
      do_ack();
    end
    check("wrap_frame_cnt", frame_cnt, 0);

    step();
    check("final_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
